// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver sampling rxd at mid-bit, buffering bytes in a FIFO
// that the CPU drains through a valid/ready register port (DATA, STATUS).
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_LSB     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        wr,
    input  logic        valid,
    output logic        ready,
    input  logic        rxd,
    output logic        rx_irq
);
    // state | meaning
    // IDLE  | line idle, waiting for a low rs
    // START | half-bit wait, then confirm start bit
    // DATA  | sample 8 data bits LSB first
    // STOP  | sample stop bit, push or flag the byte
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0] TMR_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] TMR_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    logic          r_sync1, r_sync2;
    state_t        r_state;
    logic [15:0]   r_tmr;
    logic [2:0]    r_n;
    logic [7:0]    r_shreg;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovr, r_fe;
    logic          r_ready;
    logic [31:0]   r_dout;
    logic          r_irq;

    logic w_rs, w_tc, w_stop_hit, w_full, w_empty;
    logic w_push, w_set_ovr, w_set_fe;
    logic w_acc, w_sel_stat, w_pop, w_clr;
    logic w_unused;

    assign w_rs       = r_sync2;
    assign w_tc       = (r_tmr == 16'd0);
    assign w_stop_hit = (r_state == S_STOP) && w_tc;
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = w_stop_hit && w_rs && !w_full;
    assign w_set_ovr  = w_stop_hit && w_rs && w_full;
    assign w_set_fe   = w_stop_hit && !w_rs;

    // A held valid is re-acknowledged every second cycle.
    assign w_acc      = valid && !r_ready;
    assign w_sel_stat = addr[ADDR_LSB];
    assign w_pop      = w_acc && !wr && !w_sel_stat && !w_empty;
    assign w_clr      = w_acc && wr && w_sel_stat;
    assign w_unused   = ^{addr, din};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_n     <= '0;
            r_shreg <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rs) begin
                        r_tmr   <= TMR_HALF;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (!w_tc) begin
                        r_tmr <= r_tmr - 16'd1;
                    end else if (!w_rs) begin
                        r_tmr   <= TMR_FULL;
                        r_n     <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!w_tc) begin
                        r_tmr <= r_tmr - 16'd1;
                    end else begin
                        r_shreg <= {w_rs, r_shreg[7:1]};
                        r_tmr   <= TMR_FULL;
                        if (r_n == 3'd7) r_state <= S_STOP;
                        else             r_n     <= r_n + 3'd1;
                    end
                end
                S_STOP: begin
                    if (!w_tc) r_tmr   <= r_tmr - 16'd1;
                    else       r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= r_shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Setting a flag takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            r_ovr <= w_set_ovr | (r_ovr & ~(w_clr & din[1]));
            r_fe  <= w_set_fe  | (r_fe  & ~(w_clr & din[2]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_dout  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ready <= w_acc;
            r_irq   <= ~w_empty | r_ovr | r_fe;
            if (w_acc) begin
                if (wr)
                    r_dout <= '0;
                else if (w_sel_stat)
                    r_dout <= {16'(r_count), 13'b0, r_fe, r_ovr, ~w_empty};
                else
                    r_dout <= {23'b0, w_empty, w_empty ? 8'h00 : r_mem[r_rptr]};
            end
        end
    end

    assign ready  = r_ready;
    assign dout   = r_dout;
    assign rx_irq = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames and CPU accesses checked against a
// queue-based model of the receive buffer and its sticky flags.
module tb_uart_rx_fifo;
    localparam int CPB   = 8;
    localparam int DEPTH = 16;
    localparam int LSB   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, din, dout;
    logic        wr, valid, ready, rxd, rx_irq;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_LSB(LSB)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
        .wr(wr), .valid(valid), .ready(ready), .rxd(rxd), .rx_irq(rx_irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_q[$];
    logic       m_ovr, m_fe;

    function automatic logic [31:0] m_status();
        return {16'(m_q.size()), 13'b0, m_fe, m_ovr, logic'(m_q.size() != 0)};
    endfunction

    function automatic logic [31:0] m_data_pop();
        if (m_q.size() == 0) return 32'h100;
        return {24'b0, m_q.pop_front()};
    endfunction

    function automatic logic m_irq();
        return (m_q.size() != 0) || m_ovr || m_fe;
    endfunction

    function automatic void m_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok)                m_fe = 1'b1;
        else if (m_q.size() >= DEPTH) m_ovr = 1'b1;
        else                          m_q.push_back(b);
    endfunction

    function automatic void m_clear();
        m_q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
    endfunction

    // Called at a negedge; returns at a negedge after a 2-bit idle tail.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic bus_xfer(input logic w, input logic sel, input logic [31:0] wd,
                            output logic [31:0] rd);
        logic got;
        logic [31:0] a;
        a = $urandom;
        a[LSB] = sel;
        addr = a;
        wr = w;
        din = wd;
        valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
        end
        rd = dout;
        valid = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL bus_ack: ready=%b, required 1 within 8 cycles", ready);
        end
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        // unused helper; comparisons are inline in each test
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1; rxd = 1'b1; valid = 1'b0; wr = 1'b0; addr = '0; din = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_clear();
        @(negedge clk);
        n_tests++;
        if ({ready, rx_irq, dout} !== 34'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b irq=%b dout=%h, required 0 0 0",
                     ready, rx_irq, dout);
        end
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL reset_status: got %h required %h", rd, m_status());
        end
        bus_xfer(1'b0, 1'b0, 32'h0, rd);
        n_tests++;
        if (rd !== 32'h100) begin
            n_fail++;
            $display("FAIL reset_data: got %h required %h", rd, 32'h100);
        end
    endtask

    task automatic test_single();
        logic [31:0] rd, exp;
        send_frame(8'hA5, 1'b1);
        m_frame(8'hA5, 1'b1);
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== 32'h0001_0001 || rd !== m_status()) begin
            n_fail++;
            $display("FAIL single_status: got %h required %h", rd, 32'h0001_0001);
        end
        n_tests++;
        if (rx_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL single_irq_high: got %b required 1", rx_irq);
        end
        bus_xfer(1'b0, 1'b0, 32'h0, rd);
        exp = m_data_pop();
        n_tests++;
        if (rd !== exp || rd !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL single_data: got %h required %h", rd, exp);
        end
        bus_xfer(1'b0, 1'b0, 32'h0, rd);
        exp = m_data_pop();
        n_tests++;
        if (rd !== exp) begin
            n_fail++;
            $display("FAIL single_empty_read: got %h required %h", rd, exp);
        end
        @(negedge clk);
        n_tests++;
        if (rx_irq !== m_irq()) begin
            n_fail++;
            $display("FAIL single_irq_low: got %b required %b", rx_irq, m_irq());
        end
    endtask

    task automatic test_overrun();
        logic [31:0] rd, exp;
        for (int b = 0; b < 17; b++) begin
            send_frame(8'(b), 1'b1);
            m_frame(8'(b), 1'b1);
        end
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== m_status() || rd !== 32'h0010_0003) begin
            n_fail++;
            $display("FAIL ovr_status: got %h required %h", rd, m_status());
        end
        bus_xfer(1'b1, 1'b1, 32'h2, rd);
        m_ovr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_xfer(1'b0, 1'b0, 32'h0, rd);
            exp = m_data_pop();
            n_tests++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL ovr_data[%0d]: got %h required %h", i, rd, exp);
            end
        end
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL ovr_cleared_status: got %h required %h", rd, m_status());
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] rd;
        send_frame(8'h3C, 1'b0);
        m_frame(8'h3C, 1'b0);
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== m_status() || rd[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL fe_status: got %h required %h", rd, m_status());
        end
        n_tests++;
        if (rx_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL fe_irq: got %b required 1", rx_irq);
        end
        bus_xfer(1'b1, 1'b1, 32'h4, rd);
        m_fe = 1'b0;
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL fe_cleared_status: got %h required %h", rd, m_status());
        end
        n_tests++;
        if (rx_irq !== m_irq()) begin
            n_fail++;
            $display("FAIL fe_cleared_irq: got %b required %b", rx_irq, m_irq());
        end
    endtask

    task automatic test_glitch();
        logic [31:0] rd, exp;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL glitch_status: got %h required %h", rd, m_status());
        end
        n_tests++;
        if (rx_irq !== m_irq()) begin
            n_fail++;
            $display("FAIL glitch_irq: got %b required %b", rx_irq, m_irq());
        end
        send_frame(8'h6E, 1'b1);
        m_frame(8'h6E, 1'b1);
        bus_xfer(1'b0, 1'b0, 32'h0, rd);
        exp = m_data_pop();
        n_tests++;
        if (rd !== exp) begin
            n_fail++;
            $display("FAIL glitch_recover: got %h required %h", rd, exp);
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] rd, exp;
        logic [7:0]  b1, b2;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        send_frame(b1, 1'b1);
        m_frame(b1, 1'b1);
        // Stop-bit sample lands 79 edges after the start edge is driven.
        fork
            send_frame(b2, 1'b1);
            begin
                repeat (78) @(negedge clk);
                bus_xfer(1'b0, 1'b0, 32'h0, rd);
            end
        join
        exp = m_data_pop();
        m_frame(b2, 1'b1);
        n_tests++;
        if (rd !== exp) begin
            n_fail++;
            $display("FAIL pp_old_byte: got %h required %h", rd, exp);
        end
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL pp_status: got %h required %h", rd, m_status());
        end
        bus_xfer(1'b0, 1'b0, 32'h0, rd);
        exp = m_data_pop();
        n_tests++;
        if (rd !== exp) begin
            n_fail++;
            $display("FAIL pp_new_byte: got %h required %h", rd, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, exp;
        logic [7:0]  b;
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            m_frame(b, 1'b1);
        end
        addr = '0; wr = 1'b0; din = '0; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (ready !== logic'(i % 2 == 0)) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b required %b", i, ready, (i % 2 == 0));
            end
            if (ready && i % 2 == 0) begin
                exp = m_data_pop();
                n_tests++;
                if (dout !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %h required %h", i, dout, exp);
                end
            end
        end
        valid = 1'b0;
        @(negedge clk);
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL b2b_status: got %h required %h", rd, m_status());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp;
        logic [7:0]  b;
        b = 8'h55;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        rst = 1'b0;
        m_clear();
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'h81, 1'b1);
        m_frame(8'h81, 1'b1);
        bus_xfer(1'b0, 1'b0, 32'h0, rd);
        exp = m_data_pop();
        n_tests++;
        if (rd !== exp || rd !== 32'h81) begin
            n_fail++;
            $display("FAIL rstmid_data: got %h required %h", rd, exp);
        end
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL rstmid_status: got %h required %h", rd, m_status());
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp;
        logic [7:0]  b;
        logic        ok;
        for (int it = 0; it < 20; it++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send_frame(b, ok);
            m_frame(b, ok);
            n_tests++;
            if (rx_irq !== m_irq()) begin
                n_fail++;
                $display("FAIL rand_irq[%0d]: got %b required %b", it, rx_irq, m_irq());
            end
            if ($urandom_range(0, 1) == 1) begin
                bus_xfer(1'b0, 1'b0, 32'h0, rd);
                exp = m_data_pop();
                n_tests++;
                if (rd !== exp) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: got %h required %h", it, rd, exp);
                end
            end
            if (it % 5 == 4) begin
                bus_xfer(1'b0, 1'b1, 32'h0, rd);
                n_tests++;
                if (rd !== m_status()) begin
                    n_fail++;
                    $display("FAIL rand_status[%0d]: got %h required %h", it, rd, m_status());
                end
            end
        end
        bus_xfer(1'b1, 1'b1, 32'h6, rd);
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            bus_xfer(1'b0, 1'b0, 32'h0, rd);
            exp = m_data_pop();
            n_tests++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL rand_drain[%0d]: got %h required %h", i, rd, exp);
            end
        end
        bus_xfer(1'b0, 1'b1, 32'h0, rd);
        n_tests++;
        if (rd !== m_status()) begin
            n_fail++;
            $display("FAIL rand_final_status: got %h required %h", rd, m_status());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_push_pop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
